// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and mode constants,
// used by both spi_master and spi_slave.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_WAIT_NEXT = 3'd3,
        ST_HOLD      = 3'd4,
        ST_GAP       = 3'd5
    } spi_state_e;

    // Mode 0: clock idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int SPI_BITS = 8;

    // States in which a new byte may be handed over.
    function automatic logic spi_accepts(input spi_state_e s);
        return (s == ST_IDLE) || (s == ST_WAIT_NEXT);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator. Counts 0..CLK_DIV-1 while enabled and emits
// a one-cycle tick on the last count; held at 0 while disabled so every
// enabled phase starts a full half-period.
module spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [7:0] LP_TERM = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    // Divide counter: wraps to 0 at terminal count, cleared when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (!i_en) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == LP_TERM) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tick = i_en && (r_cnt == LP_TERM);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master with byte-stream input and multi-byte frames.
// cs_n stays low across a frame; WAIT_NEXT parks the bus between bytes
// until the next byte arrives. cs_n is decoded from the state register so
// an asynchronous reset releases it immediately.
//
// state      | meaning
// IDLE       | cs_n high, waiting for the first byte of a frame
// SETUP      | cs_n low, mosi = bit7, CLK_DIV cycles before first edge
// SHIFT      | 8 bits, each CLK_DIV low + CLK_DIV high sclk cycles
// WAIT_NEXT  | mid-frame pause, sclk low, waiting for the next byte
// HOLD       | cs_n low for CLK_DIV cycles after the last byte
// GAP        | cs_n high for CLK_DIV cycles before accepting a new frame
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       cs_n,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    spi_state_e r_state;
    spi_state_e w_state_nxt;

    logic       w_en;
    logic       w_tick;
    logic       w_hs;
    logic       w_rise;
    logic       w_fall;
    logic       w_byte_end;

    logic       r_rst_done;
    logic       r_phase;
    logic       r_sclk;
    logic       r_last;
    logic       r_rx_valid;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_tx_sr;
    logic [7:0] r_rx_sr;
    logic [7:0] r_rx_data;

    spi_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .o_tick(w_tick)
    );

    assign w_hs       = tx_valid && tx_ready;
    assign w_rise     = (r_state == ST_SHIFT) && w_tick && !r_phase;
    assign w_fall     = (r_state == ST_SHIFT) && w_tick && r_phase;
    assign w_byte_end = w_fall && (r_bit_cnt == 3'(SPI_BITS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_hs)       w_state_nxt = ST_SETUP;
            ST_SETUP:     if (w_tick)     w_state_nxt = ST_SHIFT;
            ST_SHIFT:     if (w_byte_end) w_state_nxt = r_last ? ST_HOLD : ST_WAIT_NEXT;
            ST_WAIT_NEXT: if (w_hs)       w_state_nxt = ST_SHIFT;
            ST_HOLD:      if (w_tick)     w_state_nxt = ST_GAP;
            ST_GAP:       if (w_tick)     w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; tx_ready waits one edge after reset release.
    always_comb begin
        cs_n     = 1'b0;
        busy     = 1'b1;
        w_en     = 1'b1;
        tx_ready = r_rst_done && spi_accepts(r_state);
        case (r_state)
            ST_IDLE: begin
                cs_n = 1'b1;
                busy = 1'b0;
                w_en = 1'b0;
            end
            ST_WAIT_NEXT: w_en = 1'b0;
            ST_GAP:       cs_n = 1'b1;
            default: ;
        endcase
    end

    // Shift datapath: load on handshake, sample on rise, advance on fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
            r_phase    <= 1'b0;
            r_sclk     <= SPI_CPOL;
            r_last     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_tx_sr    <= 8'h00;
            r_rx_sr    <= 8'h00;
            r_rx_data  <= 8'h00;
        end else begin
            r_rst_done <= 1'b1;
            r_rx_valid <= 1'b0;
            if (w_hs) begin
                r_tx_sr   <= tx_data;
                r_last    <= tx_last;
                r_phase   <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_sclk    <= SPI_CPOL;
            end
            if (w_rise) begin
                r_sclk  <= 1'b1;
                r_phase <= 1'b1;
                r_rx_sr <= {r_rx_sr[6:0], miso};
            end
            if (w_fall) begin
                r_sclk    <= 1'b0;
                r_phase   <= 1'b0;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_end) begin
                    // Last fall: keep mosi on bit0 so the bus is quiet in WAIT_NEXT.
                    r_rx_data  <= r_rx_sr;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                end
            end
        end
    end

    assign sclk     = r_sclk;
    assign mosi     = r_tx_sr[7];
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: three instances at CLK_DIV 2, 4 and 1.
// Instance 0 loops miso to mosi, instance 1 returns ~mosi and is watched
// by a small mode-0 slave model, instance 2 has miso tied high.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [2:0][7:0] tx_data;
    logic [2:0]      tx_valid;
    logic [2:0]      tx_last;
    logic [2:0]      tx_ready_w;
    logic [2:0][7:0] rx_data_w;
    logic [2:0]      rx_valid_w;
    logic [2:0]      busy_w;
    logic [2:0]      cs_n_w;
    logic [2:0]      sclk_w;
    logic [2:0]      mosi_w;
    logic            miso0, miso1, miso2;

    assign miso0 = mosi_w[0];
    assign miso1 = ~mosi_w[1];
    assign miso2 = 1'b1;

    spi_master #(.CLK_DIV(2)) u_dut_d2 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_last(tx_last[0]),
        .tx_ready(tx_ready_w[0]), .rx_data(rx_data_w[0]), .rx_valid(rx_valid_w[0]),
        .busy(busy_w[0]), .cs_n(cs_n_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]),
        .miso(miso0)
    );

    spi_master #(.CLK_DIV(4)) u_dut_d4 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_last(tx_last[1]),
        .tx_ready(tx_ready_w[1]), .rx_data(rx_data_w[1]), .rx_valid(rx_valid_w[1]),
        .busy(busy_w[1]), .cs_n(cs_n_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]),
        .miso(miso1)
    );

    spi_master #(.CLK_DIV(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_last(tx_last[2]),
        .tx_ready(tx_ready_w[2]), .rx_data(rx_data_w[2]), .rx_valid(rx_valid_w[2]),
        .busy(busy_w[2]), .cs_n(cs_n_w[2]), .sclk(sclk_w[2]), .mosi(mosi_w[2]),
        .miso(miso2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitors, sampled on the falling edge.
    int         cyc = 0;
    int         rises    [3] = '{0, 0, 0};
    int         rxv_cnt  [3] = '{0, 0, 0};
    int         lo_run   [3] = '{0, 0, 0};
    int         hi_run   [3] = '{0, 0, 0};
    int         last_lo  [3] = '{0, 0, 0};
    int         last_hi  [3] = '{0, 0, 0};
    int         gap_viol [3] = '{0, 0, 0};
    logic [2:0] prev_sclk = 3'b000;
    int         bad_mosi2 = 0;
    int         rise_t[$];
    logic [7:0] sl_sr = 8'h00;
    int         sl_cnt = 0;
    logic [7:0] sl_q[$];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sclk_w[k] && !prev_sclk[k]) begin
                rises[k]++;
                if (k == 2) begin
                    rise_t.push_back(cyc);
                    if (mosi_w[2] !== 1'b0) bad_mosi2++;
                end
                if (k == 1) begin
                    sl_sr = {sl_sr[6:0], mosi_w[1]};
                    sl_cnt++;
                    if (sl_cnt == 8) begin
                        sl_q.push_back(sl_sr);
                        sl_cnt = 0;
                    end
                end
            end
            prev_sclk[k] = sclk_w[k];
            if (rx_valid_w[k]) rxv_cnt[k]++;
            if (cs_n_w[k]) begin
                hi_run[k]++;
                if (lo_run[k] > 0) last_lo[k] = lo_run[k];
                lo_run[k] = 0;
                if (busy_w[k] && tx_ready_w[k]) gap_viol[k]++;
            end else begin
                lo_run[k]++;
                if (hi_run[k] > 0) last_hi[k] = hi_run[k];
                hi_run[k] = 0;
            end
        end
        if (cs_n_w[1]) sl_cnt = 0;
        cyc++;
    end

    task automatic send(input int k, input logic [7:0] d, input logic last, input logic keep);
        int n;
        n = 0;
        @(negedge clk);
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        tx_last[k]  = last;
        while (tx_ready_w[k] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready", 32'(tx_ready_w[k]), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = ~d;
            tx_last[k]  = 1'b0;
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w[k] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy_w[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, v0, n, bad, mn, mx, g;
        rst_n    = 1'b0;
        tx_valid = '0;
        tx_last  = '0;
        tx_data  = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_cs_n",     32'(cs_n_w[0]),     32'd1);
        check("rst_sclk",     32'(sclk_w[0]),     32'd0);
        check("rst_mosi",     32'(mosi_w[0]),     32'd0);
        check("rst_tx_ready", 32'(tx_ready_w[0]), 32'd0);
        check("rst_rx_valid", 32'(rx_valid_w[0]), 32'd0);
        check("rst_rx_data",  32'(rx_data_w[0]),  32'h00);
        check("rst_busy",     32'(busy_w[0]),     32'd0);
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", 32'(tx_ready_w[0]), 32'd0);
        @(posedge clk);
        #1;
        check("rdy_first_edge", 32'(tx_ready_w[0]), 32'd1);

        // CLK_DIV=2, single byte 0xA5 in loopback.
        r0 = rises[0];
        v0 = rxv_cnt[0];
        send(0, 8'hA5, 1'b1, 1'b0);
        wait_idle(0);
        check("d2_rises",    32'(rises[0] - r0),   32'd8);
        check("d2_rx_data",  32'(rx_data_w[0]),    32'hA5);
        check("d2_rx_valid", 32'(rxv_cnt[0] - v0), 32'd1);
        check("d2_cs_low",   32'(last_lo[0]),      32'd36);

        // CLK_DIV=1, miso high, byte 0x00.
        rise_t.delete();
        r0 = rises[2];
        bad = bad_mosi2;
        send(2, 8'h00, 1'b1, 1'b0);
        wait_idle(2);
        check("d1_rises",    32'(rises[2] - r0),    32'd8);
        check("d1_mosi_low", 32'(bad_mosi2 - bad),  32'd0);
        check("d1_rx_data",  32'(rx_data_w[2]),     32'hFF);
        check("d1_nrise",    32'(rise_t.size()),    32'd8);
        if (rise_t.size() >= 8) begin
            mn = 1000;
            mx = 0;
            for (int i = 1; i < 8; i++) begin
                if (rise_t[i] - rise_t[i-1] < mn) mn = rise_t[i] - rise_t[i-1];
                if (rise_t[i] - rise_t[i-1] > mx) mx = rise_t[i] - rise_t[i-1];
            end
            check("d1_period_min", 32'(mn), 32'd2);
            check("d1_period_max", 32'(mx), 32'd2);
        end

        // CLK_DIV=4, three-byte frame with tx_valid held high.
        sl_q.delete();
        r0 = rises[1];
        v0 = rxv_cnt[1];
        send(1, 8'h12, 1'b0, 1'b1);
        send(1, 8'h34, 1'b0, 1'b1);
        send(1, 8'h56, 1'b1, 1'b0);
        wait_idle(1);
        check("fr_rises",    32'(rises[1] - r0),   32'd24);
        check("fr_cs_low",   32'(last_lo[1]),      32'd202);
        check("fr_rx_valid", 32'(rxv_cnt[1] - v0), 32'd3);
        check("fr_rx_data",  32'(rx_data_w[1]),    32'hA9);
        check("fr_nbytes",   32'(sl_q.size()),     32'd3);
        if (sl_q.size() == 3) begin
            check("fr_byte0", 32'(sl_q[0]), 32'h12);
            check("fr_byte1", 32'(sl_q[1]), 32'h34);
            check("fr_byte2", 32'(sl_q[2]), 32'h56);
        end

        // WAIT_NEXT stall of 50 cycles between bytes.
        sl_q.delete();
        send(1, 8'h81, 1'b0, 1'b0);
        n = 0;
        while (tx_ready_w[1] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wn_reached", 32'(tx_ready_w[1]), 32'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs_n_w[1] !== 1'b0 || sclk_w[1] !== 1'b0 ||
                tx_ready_w[1] !== 1'b1 || mosi_w[1] !== 1'b1) bad++;
        end
        check("wn_stall_bus", 32'(bad), 32'd0);
        send(1, 8'h5A, 1'b1, 1'b0);
        check("wn_mosi_bit7", 32'(mosi_w[1]),     32'd0);
        check("wn_busy",      32'(busy_w[1]),     32'd1);
        check("wn_ready_low", 32'(tx_ready_w[1]), 32'd0);
        check("wn_cs_n",      32'(cs_n_w[1]),     32'd0);
        n = 0;
        while (!sclk_w[1] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wn_first_rise", 32'(n), 32'd4);
        wait_idle(1);
        check("wn_nbytes",  32'(sl_q.size()),   32'd2);
        if (sl_q.size() == 2) begin
            check("wn_byte0", 32'(sl_q[0]), 32'h81);
            check("wn_byte1", 32'(sl_q[1]), 32'h5A);
        end
        check("wn_rx_data", 32'(rx_data_w[1]), 32'hA5);

        // Reset in the middle of 0xC3, then 0x3C.
        sl_q.delete();
        r0 = rises[1];
        v0 = rxv_cnt[1];
        send(1, 8'hC3, 1'b1, 1'b0);
        n = 0;
        while (rises[1] - r0 < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ab_reach_bit4", 32'(rises[1] - r0), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("ab_cs_n",     32'(cs_n_w[1]),     32'd1);
        check("ab_sclk",     32'(sclk_w[1]),     32'd0);
        check("ab_busy",     32'(busy_w[1]),     32'd0);
        check("ab_ready",    32'(tx_ready_w[1]), 32'd0);
        check("ab_rx_data",  32'(rx_data_w[1]),  32'h00);
        repeat (3) @(negedge clk);
        check("ab_no_rx_valid", 32'(rxv_cnt[1] - v0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ab_rdy_first_edge", 32'(tx_ready_w[1]), 32'd1);
        send(1, 8'h3C, 1'b1, 1'b0);
        wait_idle(1);
        check("ab_rx_after",  32'(rx_data_w[1]),    32'hC3);
        check("ab_rxv_after", 32'(rxv_cnt[1] - v0), 32'd1);
        check("ab_nbytes",    32'(sl_q.size()),     32'd1);
        if (sl_q.size() == 1) check("ab_byte0", 32'(sl_q[0]), 32'h3C);

        // Back-to-back frames with tx_valid high through HOLD and GAP.
        sl_q.delete();
        g = gap_viol[1];
        send(1, 8'h11, 1'b1, 1'b1);
        send(1, 8'h22, 1'b1, 1'b0);
        wait_idle(1);
        check("bb_gap_ready", 32'(gap_viol[1] - g), 32'd0);
        check("bb_cs_high",   32'(last_hi[1]),      32'd5);
        check("bb_nbytes",    32'(sl_q.size()),     32'd2);
        if (sl_q.size() == 2) begin
            check("bb_byte0", 32'(sl_q[0]), 32'h11);
            check("bb_byte1", 32'(sl_q[1]), 32'h22);
        end
        check("bb_rx_data", 32'(rx_data_w[1]), 32'hDD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
